hist_readout_streamer: RTL
==========================

Name: hist_readout_streamer

Overview:
- Read side of the time-correlation histogram memory: after a dump request, walks every bin through the memory's bin read port.
- Serialises each bin into a framed byte stream over a valid/ready handshake toward the host link (UART/USB FIFO).
- Holds the histogram frozen during the dump so the frame is self-consistent.
- Optionally issues the histogram clear command once the frame completes.

Parameters:
NUM_BINS, 256, number of histogram bins walked per frame (2..256)
ADDR_W, 8, bin address width; NUM_BINS <= 2**ADDR_W
BIN_W, 32, bin counter width; multiple of 8
RD_LAT, 1, read latency of histogram port in cycles (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle dump request
clear_after  in  1  sampled with start; 1 = clear histogram after frame
busy  out  1  high from accepted start until return to IDLE
hist_freeze  out  1  inhibits histogram accumulation while high
hist_rd_addr  out  ADDR_W  bin address to histogram read port
hist_rd_en  out  1  read strobe, one cycle per bin
hist_rd_data  in  BIN_W  bin value, valid RD_LAT cycles after hist_rd_en
hist_clear  out  1  one-cycle clear pulse to histogram (maps to clear command 2'b01)
tx_data  out  8  stream byte
tx_valid  out  1  byte valid
tx_ready  in  1  sink accepts byte
done  out  1  one-cycle pulse when frame (and clear, if any) finished

Behaviour:
- Reset values: busy=0, hist_freeze=0, hist_rd_en=0, hist_rd_addr=0, hist_clear=0, tx_valid=0, tx_data=0, done=0, state=IDLE, checksum=0.
- Transfer occurs on a cycle with tx_valid&&tx_ready. tx_valid is never dropped and tx_data never changes while tx_valid&&!tx_ready.
- Frame byte order:
  - SYNC 8'hA5.
  - COUNT = (NUM_BINS-1)[7:0].
  - Per bin, bin 0 upward: BIN_W/8 bytes, MSB first.
  - CSUM = XOR of every byte after SYNC, including COUNT.
- States:
  - IDLE: start accepted only here. Latch clear_after. Clear checksum and bin index. Assert busy and hist_freeze next cycle. Go to SYNC.
  - SYNC: present 8'hA5. On transfer go to CNT.
  - CNT: present COUNT and fold it into the checksum. On transfer go to FETCH.
  - FETCH: one cycle; hist_rd_en=1, hist_rd_addr=bin index. Go to WAIT.
  - WAIT: RD_LAT cycles. On the last WAIT cycle capture hist_rd_data into the shift register and set the byte counter to BIN_W/8-1. Go to SEND.
  - SEND: present shift register MSB byte. On each transfer fold it into the checksum and shift left by 8. After the last byte: if bin index==NUM_BINS-1 go to CSUM, else increment the index and go to FETCH.
  - CSUM: present checksum. On transfer go to CLR if the latched clear_after=1, else FIN.
  - CLR: hist_clear=1 for exactly one cycle. Go to FIN.
  - FIN: done=1 for one cycle. busy and hist_freeze deassert on the same edge as the return to IDLE.
- Bin index is ADDR_W+1 bits internally; no wrap at NUM_BINS=2**ADDR_W. The last index is NUM_BINS-1 (0xFF for 256).
- Minimum per-bin overhead: 1+RD_LAT cycles with no bytes presented. Throughput is otherwise 1 byte/cycle when tx_ready=1.
- start while busy: ignored, not queued. start coincident with rst: rst wins.
- tx_ready held low indefinitely: the block stalls in place; freeze stays asserted.
- rst mid-frame: all outputs return to reset values on the next edge. Frame truncated; no clear issued; no done pulse.
- hist_clear is never asserted while hist_rd_en is pending or data is in flight.

Decomposition:
- Shared package hist_pkg:
  - HIST_SYNC_BYTE = 8'hA5
  - HIST_CMD_CLEAR = 2'b01
  - state enumeration typedef hist_rd_state_t
  - default NUM_BINS/BIN_W constants shared with the histogram memory
- No sub-module required. The byte shift register/counter may be split out as hist_bin_serializer if reused by a future DMA path; single module preferred.

Test Plan:
- NUM_BINS=4, BIN_W=32, bins {1,2,3,4}, tx_ready=1, start, clear_after=0 -> bytes A5 03 00 00 00 01 00 00 00 02 00 00 00 03 00 00 00 04 07. No hist_clear. done pulses once. busy low afterwards.
- Same setup, tx_ready toggled pseudo-randomly -> identical 19-byte sequence. tx_data stable on every stalled cycle. hist_freeze high throughout.
- Same setup with clear_after=1 -> hist_clear one-cycle pulse after CSUM transfer and before done. Subsequent dump yields A5 03, sixteen 00 bytes, CSUM 03.
- NUM_BINS=256 default, bin k = k -> 1027 bytes. COUNT byte FF. Last bin bytes 00 00 00 FF. hist_rd_addr reaches FF without wrapping to 00 mid-frame.
- start asserted during SEND and again on FIN cycle -> both ignored. Exactly one frame emitted.
- rst asserted during bin 2 of the NUM_BINS=4 frame -> next cycle tx_valid=0, busy=0, hist_freeze=0. No hist_clear, no done. A fresh start yields a complete correct frame.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared definitions for the time-correlation histogram memory and its readout path.
package hist_pkg;

  localparam logic [7:0] HIST_SYNC_BYTE = 8'hA5;
  localparam logic [1:0] HIST_CMD_CLEAR = 2'b01;

  localparam int HIST_NUM_BINS = 256;
  localparam int HIST_BIN_W    = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CNT,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_CSUM,
    ST_CLR,
    ST_FIN
  } hist_rd_state_t;

endpackage

// File: rtl/hist_readout_streamer.sv
// Histogram dump engine: walks every bin, frames it as SYNC/COUNT/bins/CSUM bytes
// over valid/ready, freezes accumulation meanwhile and optionally clears afterwards.
module hist_readout_streamer
  import hist_pkg::*;
#(
  parameter int NUM_BINS = HIST_NUM_BINS,
  parameter int ADDR_W   = 8,
  parameter int BIN_W    = HIST_BIN_W,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_after,
  output logic              busy,
  output logic              hist_freeze,
  output logic [ADDR_W-1:0] hist_rd_addr,
  output logic              hist_rd_en,
  input  logic [BIN_W-1:0]  hist_rd_data,
  output logic              hist_clear,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam int NBYTES = BIN_W / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDX_W  = ADDR_W + 1;

  // Index is one bit wider than the address so NUM_BINS == 2**ADDR_W never wraps.
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BINS - 1);
  localparam logic [7:0]        COUNT_BYTE = 8'(NUM_BINS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(NBYTES - 1);
  localparam logic [1:0]        WAIT_INIT  = 2'(RD_LAT - 1);

  hist_rd_state_t     state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [1:0]         wait_q, wait_d;
  logic [7:0]         csum_q, csum_d;
  logic               clr_after_q, clr_after_d;

  logic               xfer;
  logic [7:0]         send_byte;
  logic [1:0]         clr_cmd;

  assign xfer         = tx_valid && tx_ready;
  assign send_byte    = shift_q[BIN_W-1 -: 8];
  assign hist_rd_addr = idx_q[ADDR_W-1:0];

  // NOTE: reset is synchronous, so it lives inside the clocked block and every
  // register, including the data shift register, is returned to a known value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      wait_q      <= '0;
      csum_q      <= '0;
      clr_after_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      wait_q      <= wait_d;
      csum_q      <= csum_d;
      clr_after_q <= clr_after_d;
    end
  end

  // NOTE: every signal written here gets a hold-value default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    wait_d      = wait_q;
    csum_d      = csum_q;
    clr_after_d = clr_after_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_after_d = clear_after;
          csum_d      = '0;
          idx_d       = '0;
          state_d     = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (xfer) state_d = ST_CNT;
      end
      ST_CNT: begin
        if (xfer) begin
          csum_d  = csum_q ^ COUNT_BYTE;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        wait_d  = WAIT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          shift_d = hist_rd_data;
          bcnt_d  = LAST_BYTE;
          state_d = ST_SEND;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          csum_d  = csum_q ^ send_byte;
          shift_d = shift_q << 8;
          if (bcnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_CSUM;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) state_d = clr_after_q ? ST_CLR : ST_FIN;
      end
      ST_CLR:  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so data presented is stable while stalled.
  always_comb begin
    busy       = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    hist_rd_en = 1'b0;
    clr_cmd    = '0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_SYNC:  begin tx_valid = 1'b1; tx_data = HIST_SYNC_BYTE; end
      ST_CNT:   begin tx_valid = 1'b1; tx_data = COUNT_BYTE;     end
      ST_FETCH: hist_rd_en = 1'b1;
      ST_SEND:  begin tx_valid = 1'b1; tx_data = send_byte;      end
      ST_CSUM:  begin tx_valid = 1'b1; tx_data = csum_q;         end
      ST_CLR:   clr_cmd = HIST_CMD_CLEAR;
      ST_FIN:   done = 1'b1;
      default:  ;
    endcase
  end

  assign hist_freeze = busy;
  assign hist_clear  = (clr_cmd == HIST_CMD_CLEAR);

endmodule
